nbcac_decoder_seq: RTL and testbench
====================================

Name: nbcac_decoder_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 16-wire NBCAC decoder.
- Converts one CODE_W-wire Fibonacci-numeral-system (FNS) codeword into a DATA_W-bit binary word, accumulating BITS_PER_CYCLE weighted wires per clock.
- Uses valid/ready handshakes on both sides, flags codewords whose value is out of range, and keeps a saturating error count.
- Sits on the receive side of a CAC bus, between the wire sampler and the consumer.

Parameters:
- CODE_W, 16: codeword wires; bit index 1..CODE_W, LSB = wire 1.
- DATA_W, 11: decoded data width.
- BITS_PER_CYCLE, 4: wires accumulated per BUSY cycle; must divide CODE_W.
- ERRCNT_W, 16: width of the saturating error counter.

Ports:
- clock, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- codein, input, [CODE_W:1]: codeword.
- in_valid, input, 1: codein valid.
- in_ready, output, 1: block can accept a codeword.
- dataout, output, [DATA_W-1:0]: decoded word, registered.
- range_err, output, 1: decoded value ≥ 2^DATA_W; qualified by out_valid.
- out_valid, output, 1: dataout/range_err valid.
- out_ready, input, 1: consumer accepts the result.
- err_cnt, output, [ERRCNT_W-1:0]: saturating count of delivered range errors.
- err_clr, input, 1: synchronous clear of err_cnt.

Behaviour:
- Weights: f1=1, f2=2, fi=f(i-1)+f(i-2). Value V = sum of codein[i]*fi. Accumulator width ACC_W = clog2(f(CODE_W+2)-1); for CODE_W=16 this is 13 bits, with max V = 4179.
- NSTEP = CODE_W/BITS_PER_CYCLE.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept happens on in_valid && in_ready. On accept:
  - codein is latched into an internal register; later codein changes are ignored.
  - acc ← 0, step ← 0, state → BUSY.
- BUSY, each cycle: acc += weighted sum of slice wires [step*B+1 .. (step+1)*B], then step++.
  - After the slice with step = NSTEP-1, state → DONE.
  - In that same edge, dataout ← final V[DATA_W-1:0] (truncated) and range_err ← (V ≥ 2^DATA_W).
- Latency: out_valid rises exactly NSTEP clock edges after the accept edge. Default is 4 cycles; BITS_PER_CYCLE=CODE_W gives 1 cycle.
- DONE:
  - dataout, range_err and out_valid hold stable while out_ready=0.
  - On out_ready: if in_valid is also high, accept the new word and go to BUSY (back-to-back). Otherwise go to IDLE.
  - Maximum throughput: one word per NSTEP+1 cycles.
- err_cnt increments on each delivered handshake (out_valid && out_ready) with range_err=1. It saturates at all-ones.
  - err_clr has priority over an increment in the same cycle; the result is 0.
- Reset (also mid-BUSY or in DONE) brings all outputs to 0 and state to IDLE:
  - dataout=0, range_err=0, out_valid=0, err_cnt=0.
  - Any in-flight word is discarded.
  - in_ready=0 while rst_n is low, and 1 from the first cycle after release.
- in_valid is ignored in BUSY. The producer must hold codein/in_valid until in_ready.

Decomposition:
- Package nbcac_pkg:
  - function fib_weight(i) returning fi.
  - function nbcac_acc_w(CODE_W).
  - localparam state encoding {IDLE, BUSY, DONE}.
- Sub-module nbcac_slice_sum:
  - Combinational; computes the weighted sum of one BITS_PER_CYCLE slice, given the slice's base index.
  - Weights come from fib_weight.

Test Plan:
- Reset then codein=16'h0001, in_valid 1 cycle → in_ready drops; after 4 edges: out_valid=1, dataout=1, range_err=0.
- codein=16'h8000 (wire 16 only) → dataout=1597, range_err=0. codein=16'h0003 → dataout=3.
- codein=16'hFFFF → V=4179, dataout=83, range_err=1. After handshake, err_cnt=1.
  - Then codein=16'hC000 → V=2584, dataout=536, range_err=1, err_cnt=2.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
  - Raise out_ready with in_valid=1 (codein=16'h0002) → next result 2 appears exactly 4 edges later.
- Assert rst_n=0 during BUSY step 2 → all outputs 0 immediately.
  - After release: no stale out_valid; a fresh decode of 16'h0005 returns 4.
- err_cnt at all-ones plus one more error → stays all-ones. err_clr together with an error handshake → err_cnt=0.
- Re-run the bench with BITS_PER_CYCLE=16 (latency 1) and BITS_PER_CYCLE=1 (latency 16) on the same vectors.

Source files
------------

// File: rtl/nbcac_decoder_seq_pkg.sv
// Shared constants and elaboration-time helpers for the sequential NBCAC decoder.
// Fibonacci weights: f1=1, f2=2, fi=f(i-1)+f(i-2).
package nbcac_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned fib_weight(input int unsigned i);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        if (i == 0) return 0;
        if (i == 1) return 1;
        a = 1;
        b = 2;
        for (int unsigned k = 2; k < i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Accumulator must hold the all-ones codeword value f(code_w+2)-2.
    function automatic int unsigned nbcac_acc_w(input int unsigned code_w);
        int unsigned m;
        int unsigned w;
        m = fib_weight(code_w + 2) - 1;
        w = 1;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'(1) << k) <= 64'(m)) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nbcac_decoder_seq_slice_sum.sv
// Combinational weighted sum of one codeword slice whose lowest wire is base+1.
module nbcac_slice_sum
    import nbcac_pkg::*;
#(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned BITS   = 4,
    parameter int unsigned ACC_W  = 13,
    parameter int unsigned IDX_W  = 5
) (
    input  logic [BITS-1:0]  slice,
    input  logic [IDX_W-1:0] base,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] wtab [CODE_W+1];

    for (genvar k = 0; k <= CODE_W; k++) begin : g_wtab
        localparam logic [ACC_W-1:0] W_K = ACC_W'(fib_weight(k));
        assign wtab[k] = W_K;
    end

    always_comb begin
        sum = '0;
        for (int unsigned j = 0; j < BITS; j++) begin
            if (slice[j]) sum = sum + wtab[base + IDX_W'(j + 1)];
        end
    end

endmodule

// File: rtl/nbcac_decoder_seq.sv
// Multi-cycle FNS (Fibonacci) codeword to binary decoder with valid/ready on
// both sides, range flag and saturating range-error counter.
module nbcac_decoder_seq
    import nbcac_pkg::*;
#(
    parameter int unsigned CODE_W         = 16,
    parameter int unsigned DATA_W         = 11,
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned ERRCNT_W       = 16
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [CODE_W:1]     codein,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   dataout,
    output logic                range_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_clr
);

    localparam int unsigned ACC_W  = nbcac_acc_w(CODE_W);
    localparam int unsigned NSTEP  = CODE_W / BITS_PER_CYCLE;
    localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int unsigned IDX_W  = $clog2(CODE_W + 1);

    logic [1:0]                 state;
    logic [CODE_W:1]            code_q;
    logic [ACC_W-1:0]           acc;
    logic [STEP_W-1:0]          step;
    logic [IDX_W-1:0]           base;
    logic [BITS_PER_CYCLE-1:0]  slice;
    logic [ACC_W-1:0]           slice_sum;
    logic [ACC_W-1:0]           next_acc;
    logic [ACC_W+DATA_W-1:0]    wide_acc;
    logic                       accept;
    logic                       last_step;

    // in_ready is forced low while reset is asserted, independent of state.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: in_ready = 1'b1;
                ST_DONE: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (step == STEP_W'(NSTEP - 1));
    assign base      = IDX_W'(step) * IDX_W'(BITS_PER_CYCLE);
    assign slice     = BITS_PER_CYCLE'(code_q >> base);
    assign next_acc  = acc + slice_sum;
    assign wide_acc  = {{DATA_W{1'b0}}, next_acc};

    nbcac_slice_sum #(
        .CODE_W (CODE_W),
        .BITS   (BITS_PER_CYCLE),
        .ACC_W  (ACC_W),
        .IDX_W  (IDX_W)
    ) u_slice_sum (
        .slice  (slice),
        .base   (base),
        .sum    (slice_sum)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            code_q    <= '0;
            acc       <= '0;
            step      <= '0;
            dataout   <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    acc  <= next_acc;
                    step <= step + STEP_W'(1);
                    if (last_step) begin
                        state     <= ST_DONE;
                        dataout   <= wide_acc[DATA_W-1:0];
                        range_err <= |wide_acc[ACC_W+DATA_W-1:DATA_W];
                    end
                end
                ST_DONE: begin
                    if (out_ready && !in_valid) state <= ST_IDLE;
                end
                default: ;
            endcase
            // Accept overrides the DONE->IDLE move for back-to-back words.
            if (accept) begin
                state  <= ST_BUSY;
                code_q <= codein;
                acc    <= '0;
                step   <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && range_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nbcac_decoder_seq.sv
// Self-checking bench for nbcac_decoder_seq: directed vectors, stalls, reset
// mid-decode, counter saturation/clear and random codewords vs. an FNS model.
module tb_nbcac_decoder_seq;

    parameter int BPC = 4;
    localparam int CW    = 16;
    localparam int DW    = 11;
    localparam int ECW   = 4;
    localparam int NSTEP = CW / BPC;
    localparam int ERRMAX = (1 << ECW) - 1;

    logic            clock = 1'b0;
    logic            rst_n = 1'b0;
    logic [CW:1]     codein = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   dataout;
    logic            range_err;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ECW-1:0]  err_cnt;
    logic            err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int err_exp = 0;

    nbcac_decoder_seq #(
        .CODE_W         (CW),
        .DATA_W         (DW),
        .BITS_PER_CYCLE (BPC),
        .ERRCNT_W       (ECW)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .codein    (codein),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .range_err (range_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clock = ~clock;

    function automatic int unsigned fns_value(input logic [CW:1] c);
        int unsigned f [1:CW];
        int unsigned v;
        f[1] = 1;
        f[2] = 2;
        for (int i = 3; i <= CW; i++) f[i] = f[i-1] + f[i-2];
        v = 0;
        for (int i = 1; i <= CW; i++) if (c[i]) v += f[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, NSTEP);
    endtask

    task automatic run(input logic [CW:1] code, input int stall, input string tag);
        int n;
        int unsigned v;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        codein = code;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        codein = ~code;
        chk({tag, "_busy_in_ready"}, in_ready, 0);
        wait_out(tag);
        v = fns_value(code);
        chk({tag, "_dataout"}, dataout, v % (1 << DW));
        chk({tag, "_range_err"}, range_err, (v >= (1 << DW)) ? 1 : 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_stall_hold"}, dataout, v % (1 << DW));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (v >= (1 << DW) && err_exp < ERRMAX) err_exp++;
        chk({tag, "_err_cnt"}, err_cnt, err_exp);
        chk({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int unsigned v;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        #20;
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        run(16'h0001, 0, "w0001");
        run(16'h8000, 0, "w8000");
        run(16'h0003, 1, "w0003");
        run(16'hFFFF, 0, "wFFFF");
        run(16'hC000, 2, "wC000");
        chk("err_two", err_cnt, 2);

        // Stall in DONE, then back-to-back accept on the delivery edge.
        codein = 16'h0013;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("hold");
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("hold_dataout", dataout, 11);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        codein = 16'h0002;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_out("b2b");
        chk("b2b_dataout", dataout, 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset asserted in the middle of a decode.
        codein = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat ((NSTEP > 2) ? 2 : 0) tick();
        rst_n = 1'b0;
        #1;
        err_exp = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_dataout", dataout, 0);
        chk("midrst_range_err", range_err, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_in_ready", in_ready, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rel_out_valid", out_valid, 0);
        chk("rel_in_ready", in_ready, 1);
        run(16'h0005, 0, "w0005");

        for (int i = 0; i < 24; i++) begin
            run(CW'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        for (int i = 0; i < ERRMAX + 3; i++) run(16'hFFFF, 0, "sat");
        chk("sat_all_ones", err_cnt, ERRMAX);

        // Clear wins over a simultaneous error delivery.
        codein = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("clr");
        out_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        out_ready = 1'b0;
        err_clr = 1'b0;
        err_exp = 0;
        chk("clr_err_cnt", err_cnt, 0);

        v = fns_value(16'hC000);
        run(16'hC000, 0, "post_clr");
        chk("post_clr_model", v, 2584);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
